// File: rtl/delayed_write_arbiter_pkg.sv
// rtl/delayed_write_arbiter_pkg.sv - shared state encodings and sizing helpers for the delayed write arbiter
package delayed_write_arbiter_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Counter must hold DELAY-1 and still have headroom for the zero test.
    function automatic int cnt_width(input int delay);
        return $clog2(delay) + 1;
    endfunction

    function automatic int ptr_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/delayed_write_arbiter_rr_pick.sv
// rtl/delayed_write_arbiter_rr_pick.sv - combinational round-robin picker, search starts at ptr and wraps
module delayed_write_arbiter_rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] win,
    output logic             any
);

    int idx;

    // Walk from the farthest slot back to ptr so the nearest set request is the last write.
    always_comb begin
        win = '0;
        any = 1'b0;
        idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                win = PTR_W'(idx);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/delayed_write_arbiter.sv
// rtl/delayed_write_arbiter.sv - round-robin shared result register with a fixed capture-to-commit delay
module delayed_write_arbiter
    import delayed_write_arbiter_pkg::*;
#(
    parameter int               NREQ     = 4,
    parameter int               WIDTH    = 4,
    parameter int               DELAY    = 5,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic                  flush,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      value,
    output logic                  busy
);

    localparam int PTR_W = ptr_width(NREQ);
    localparam int CNT_W = cnt_width(DELAY);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;

    logic [PTR_W-1:0] pick_win;
    logic             pick_any;

    delayed_write_arbiter_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .win (pick_win),
        .any (pick_any)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        hold_d  = hold_q;
        value_d = value_q;
        gnt_d   = '0;
        done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    hold_d          = wdata[int'(pick_win)*WIDTH +: WIDTH];
                    gnt_d[pick_win] = 1'b1;
                    cnt_d           = CNT_W'(DELAY - 1);
                    win_d           = pick_win;
                    state_d         = ST_WAIT;
                    ptr_d           = (pick_win == PTR_W'(NREQ - 1)) ? '0 : pick_win + 1'b1;
                end
            end
            ST_WAIT: begin
                // An abort on the final count still beats the commit.
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    value_d        = hold_q;
                    done_d[win_q]  = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            win_q   <= '0;
            hold_q  <= '0;
            value_q <= INIT_VAL;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            hold_q  <= hold_d;
            value_q <= value_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign value = value_q;
    assign busy  = (state_q == ST_WAIT);

endmodule
